convpress_mac_node: RTL

//  Parametrised Tn-lane synapse multiply / adder-tree / accumulate node for the convpress datapath.
//  Per input brick: out[j] += sum_i nbin[i]*sb[j*Tn+i], for j,i in 0..Tn-1.

---
 rtl/convpress_mac_node.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/convpress_mac_node.sv
// Tn-lane synapse MAC node: per-brick products, lane adder trees, saturating accumulators,
// then a rescaled, saturated (optionally ReLU'd) output brick with a per-lane zero mask.
module convpress_mac_node #(
    parameter int N      = 16,
    parameter int Tn     = 16,
    parameter int FRAC   = 8,
    parameter int ACC_W  = 2*N+8,
    parameter int PASS_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [PASS_W-1:0]    i_cfg_passes,
    input  logic                 i_cfg_relu,
    input  logic                 i_start,
    output logic                 o_busy,
    input  logic                 i_in_valid,
    output logic                 o_in_ready,
    input  logic [Tn*N-1:0]      i_nbin_data,
    input  logic [Tn*Tn*N-1:0]   i_sb_data,
    output logic                 o_out_valid,
    input  logic                 i_out_ready,
    output logic [Tn*N-1:0]      o_out_data,
    output logic [Tn-1:0]        o_out_zero_mask,
    output logic                 o_done
);
    localparam int PW = 2*N;
    localparam int SW = 2*N + $clog2(Tn);
    localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
    localparam logic [N-1:0]     OUT_MAX = {1'b0, {(N-1){1'b1}}};
    localparam logic [N-1:0]     OUT_MIN = {1'b1, {(N-1){1'b0}}};

    typedef enum logic [2:0] {S_IDLE, S_RUN, S_DRAIN, S_OUT, S_DONE} state_t;

    state_t                  state_q, state_d;
    logic [PASS_W-1:0]       passes_q, passes_d;
    logic [PASS_W-1:0]       count_q, count_d, count_inc;
    logic                    relu_q, relu_d;
    logic                    drain_q, drain_d;
    logic                    s1_valid_q, s1_valid_d;
    logic signed [PW-1:0]    prod_q [Tn*Tn];
    logic signed [PW-1:0]    prod_d [Tn*Tn];
    logic signed [ACC_W-1:0] acc_q [Tn];
    logic signed [ACC_W-1:0] acc_d [Tn];
    logic [Tn*N-1:0]         out_data_q, out_data_d;
    logic [Tn-1:0]           out_mask_q, out_mask_d;

    logic                    accept;
    logic signed [SW-1:0]    lane_sum [Tn];
    logic signed [ACC_W:0]   acc_wide [Tn];
    logic [ACC_W-1:0]        acc_sat  [Tn];
    logic signed [ACC_W-1:0] shifted  [Tn];
    logic [Tn*N-1:0]         out_word;
    logic [Tn-1:0]           out_mask_w;

    assign accept    = i_in_valid && (state_q == S_RUN);
    assign count_inc = count_q + PASS_W'(1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= S_IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (i_start) state_d = S_RUN;
            S_RUN:   if (accept && count_inc == passes_q) state_d = S_DRAIN;
            S_DRAIN: if (drain_q) state_d = S_OUT;
            S_OUT:   if (i_out_ready) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        o_busy          = (state_q != S_IDLE);
        o_in_ready      = (state_q == S_RUN);
        o_out_valid     = (state_q == S_OUT);
        o_done          = (state_q == S_DONE);
        o_out_data      = out_data_q;
        o_out_zero_mask = out_mask_q;
    end

    // Adder trees, saturating accumulate, and rescale/saturate/ReLU of the current accumulators.
    always_comb begin
        out_word   = '0;
        out_mask_w = '0;
        for (int unsigned j = 0; j < Tn; j++) begin
            lane_sum[j] = '0;
            for (int unsigned i = 0; i < Tn; i++)
                lane_sum[j] = lane_sum[j] + SW'(prod_q[j*Tn+i]);
            acc_wide[j] = (ACC_W+1)'(acc_q[j]) + (ACC_W+1)'(lane_sum[j]);
            if (acc_wide[j][ACC_W] != acc_wide[j][ACC_W-1])
                acc_sat[j] = acc_wide[j][ACC_W] ? ACC_MIN : ACC_MAX;
            else
                acc_sat[j] = acc_wide[j][ACC_W-1:0];
            shifted[j] = acc_q[j] >>> FRAC;
            if ((&shifted[j][ACC_W-1:N-1]) || !(|shifted[j][ACC_W-1:N-1]))
                out_word[j*N +: N] = shifted[j][N-1:0];
            else
                out_word[j*N +: N] = shifted[j][ACC_W-1] ? OUT_MIN : OUT_MAX;
            if (relu_q && out_word[j*N+N-1])
                out_word[j*N +: N] = '0;
            out_mask_w[j] = (out_word[j*N +: N] == '0);
        end
    end

    always_comb begin
        passes_d   = passes_q;
        relu_d     = relu_q;
        count_d    = count_q;
        drain_d    = 1'b0;
        s1_valid_d = accept;
        prod_d     = prod_q;
        acc_d      = acc_q;
        out_data_d = out_data_q;
        out_mask_d = out_mask_q;
        if (state_q == S_IDLE && i_start) begin
            passes_d = (i_cfg_passes == '0) ? PASS_W'(1) : i_cfg_passes;
            relu_d   = i_cfg_relu;
            count_d  = '0;
            acc_d    = '{default: '0};
        end
        if (accept) begin
            count_d = count_inc;
            for (int unsigned j = 0; j < Tn; j++)
                for (int unsigned i = 0; i < Tn; i++)
                    prod_d[j*Tn+i] = PW'($signed(i_nbin_data[i*N +: N])) *
                                     PW'($signed(i_sb_data[(j*Tn+i)*N +: N]));
        end
        if (state_q == S_DRAIN)
            drain_d = !drain_q;
        if (s1_valid_q)
            for (int unsigned j = 0; j < Tn; j++)
                acc_d[j] = acc_sat[j];
        if (state_q == S_DRAIN && drain_q) begin
            out_data_d = out_word;
            out_mask_d = out_mask_w;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            passes_q   <= PASS_W'(1);
            relu_q     <= 1'b0;
            count_q    <= '0;
            drain_q    <= 1'b0;
            s1_valid_q <= 1'b0;
            prod_q     <= '{default: '0};
            acc_q      <= '{default: '0};
            out_data_q <= '0;
            out_mask_q <= '0;
        end else begin
            passes_q   <= passes_d;
            relu_q     <= relu_d;
            count_q    <= count_d;
            drain_q    <= drain_d;
            s1_valid_q <= s1_valid_d;
            prod_q     <= prod_d;
            acc_q      <= acc_d;
            out_data_q <= out_data_d;
            out_mask_q <= out_mask_d;
        end
    end
endmodule
